// File: rtl/register_bank_16x16.sv
// register_bank_16x16
// Sixteen WIDTH-bit datapath registers with one write port, one
// increment/decrement port and a sequenced clear engine that zeroes one
// register per cycle, starting at CLR_START.
// Optional build macro REG0_HARDWIRED_ZERO_EN: register 0 reads as constant
// zero, and writes or inc/dec aimed at it are silently ignored.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | normal operation: writes and inc/dec accepted
// ST_CLEAR | clear engine running; one register zeroed per cycle,
//          | every write and inc/dec request dropped
module register_bank_16x16 #(
   parameter int         WIDTH     = 16,
   parameter logic [3:0] CLR_START = 4'd0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [3:0]       wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             incdec_en,
   input  logic [3:0]       incdec_addr,
   input  logic             incdec_dir,
   input  logic             clr_req,
   output logic [WIDTH-1:0] data0,
   output logic [WIDTH-1:0] data1,
   output logic [WIDTH-1:0] data2,
   output logic [WIDTH-1:0] data3,
   output logic [WIDTH-1:0] data4,
   output logic [WIDTH-1:0] data5,
   output logic [WIDTH-1:0] data6,
   output logic [WIDTH-1:0] data7,
   output logic [WIDTH-1:0] data8,
   output logic [WIDTH-1:0] data9,
   output logic [WIDTH-1:0] data10,
   output logic [WIDTH-1:0] data11,
   output logic [WIDTH-1:0] data12,
   output logic [WIDTH-1:0] data13,
   output logic [WIDTH-1:0] data14,
   output logic [WIDTH-1:0] data15,
   output logic             busy,
   output logic             clr_done,
   output logic             wr_drop,
   output logic             wrap_flag
);

   localparam logic [0:0]       ST_IDLE  = 1'b0;
   localparam logic [0:0]       ST_CLEAR = 1'b1;
   // The clear index wraps mod 16, so the last register cleared is the one
   // just before the starting index.
   localparam logic [3:0]       CLR_LAST = CLR_START - 4'd1;
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] reg_q [16];
   logic [WIDTH-1:0] reg_d [16];
   logic [0:0]       state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             clr_done_q, clr_done_d;
   logic             wr_drop_q, wr_drop_d;
   logic             wrap_flag_q, wrap_flag_d;

   logic [WIDTH-1:0] incdec_cur;
   logic [WIDTH-1:0] incdec_nxt;
   logic             incdec_wraps;
   logic             wr_ok;
   logic             incdec_ok;
   logic             same_addr_clash;

   // Inc/dec arithmetic on the addressed register, and address qualification.
   always_comb begin
      incdec_cur   = reg_q[incdec_addr];
      incdec_nxt   = incdec_dir ? (incdec_cur - ONE) : (incdec_cur + ONE);
      incdec_wraps = incdec_dir ? (incdec_cur == '0) : (incdec_cur == '1);
`ifdef REG0_HARDWIRED_ZERO_EN
      wr_ok        = (wr_addr != 4'd0);
      incdec_ok    = (incdec_addr != 4'd0);
`else
      wr_ok        = 1'b1;
      incdec_ok    = 1'b1;
`endif
      // A clash on a hardwired register 0 is ignored outright, not dropped.
      same_addr_clash = wr_en && incdec_en && wr_ok && (wr_addr == incdec_addr);
   end

   // Next-state logic for the bank, the FSM and the status pulses.
   always_comb begin
      reg_d       = reg_q;
      state_d     = state_q;
      cnt_d       = cnt_q;
      clr_done_d  = 1'b0;
      wr_drop_d   = 1'b0;
      wrap_flag_d = wrap_flag_q;
      case (state_q)
         ST_IDLE: begin
            if (incdec_en && incdec_ok && !same_addr_clash) begin
               reg_d[incdec_addr] = incdec_nxt;
               if (incdec_wraps) begin
                  wrap_flag_d = 1'b1;
               end
            end
            if (wr_en && wr_ok) begin
               reg_d[wr_addr] = wr_data;
            end
            wr_drop_d = same_addr_clash;
            // Entering CLEAR wipes the wrap history, even one set this cycle.
            if (clr_req) begin
               state_d     = ST_CLEAR;
               wrap_flag_d = 1'b0;
            end
         end
         ST_CLEAR: begin
            reg_d[cnt_q] = '0;
            cnt_d        = cnt_q + 4'd1;
            wr_drop_d    = wr_en || incdec_en;
            if (cnt_q == CLR_LAST) begin
               state_d    = ST_IDLE;
               clr_done_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = CLR_START;
         end
      endcase
`ifdef REG0_HARDWIRED_ZERO_EN
      reg_d[0] = '0;
`endif
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) begin
            reg_q[i] <= '0;
         end
         state_q     <= ST_IDLE;
         cnt_q       <= CLR_START;
         clr_done_q  <= 1'b0;
         wr_drop_q   <= 1'b0;
         wrap_flag_q <= 1'b0;
      end else begin
         reg_q       <= reg_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         clr_done_q  <= clr_done_d;
         wr_drop_q   <= wr_drop_d;
         wrap_flag_q <= wrap_flag_d;
      end
   end

`ifdef REG0_HARDWIRED_ZERO_EN
   assign data0 = '0;
`else
   assign data0 = reg_q[0];
`endif
   assign data1     = reg_q[1];
   assign data2     = reg_q[2];
   assign data3     = reg_q[3];
   assign data4     = reg_q[4];
   assign data5     = reg_q[5];
   assign data6     = reg_q[6];
   assign data7     = reg_q[7];
   assign data8     = reg_q[8];
   assign data9     = reg_q[9];
   assign data10    = reg_q[10];
   assign data11    = reg_q[11];
   assign data12    = reg_q[12];
   assign data13    = reg_q[13];
   assign data14    = reg_q[14];
   assign data15    = reg_q[15];
   assign busy      = (state_q == ST_CLEAR);
   assign clr_done  = clr_done_q;
   assign wr_drop   = wr_drop_q;
   assign wrap_flag = wrap_flag_q;

endmodule

// File: tb/tb_register_bank_16x16.sv
// Testbench for register_bank_16x16: directed scenarios followed by random
// traffic, all checked every cycle against a behavioural model of the bank.
module tb_register_bank_16x16;

   localparam int CLR_START = 0;

   logic        clk;
   logic        reset;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [15:0] wr_data;
   logic        incdec_en;
   logic [3:0]  incdec_addr;
   logic        incdec_dir;
   logic        clr_req;
   logic [15:0] dq [16];
   logic        busy, clr_done, wr_drop, wrap_flag;

   int n_chk  = 0;
   int n_pass = 0;

   // behavioural model state
   int unsigned m_reg [16];
   int          m_rem;      // clear cycles still to run; 0 means idle
   bit          m_done, m_drop, m_wrap;

   register_bank_16x16 #(.WIDTH(16), .CLR_START(4'(CLR_START))) dut (
      .clk(clk), .reset(reset),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .incdec_en(incdec_en), .incdec_addr(incdec_addr), .incdec_dir(incdec_dir),
      .clr_req(clr_req),
      .data0(dq[0]), .data1(dq[1]), .data2(dq[2]), .data3(dq[3]),
      .data4(dq[4]), .data5(dq[5]), .data6(dq[6]), .data7(dq[7]),
      .data8(dq[8]), .data9(dq[9]), .data10(dq[10]), .data11(dq[11]),
      .data12(dq[12]), .data13(dq[13]), .data14(dq[14]), .data15(dq[15]),
      .busy(busy), .clr_done(clr_done), .wr_drop(wr_drop), .wrap_flag(wrap_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic idle_inputs();
      reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      incdec_en = 1'b0; incdec_addr = '0; incdec_dir = 1'b0; clr_req = 1'b0;
   endtask

   // Advance one clock: predict from the current inputs, then compare everything.
   task automatic cycle();
      int unsigned nm [16];
      int          n_rem;
      bit          n_done, n_drop, n_wrap, wr_take, id_take;
      nm = m_reg; n_rem = m_rem; n_wrap = m_wrap; n_done = 0; n_drop = 0;
      if (reset) begin
         foreach (nm[i]) nm[i] = 0;
         n_rem = 0; n_wrap = 0;
      end else if (m_rem > 0) begin
         nm[(CLR_START + 16 - m_rem) % 16] = 0;
         n_drop = wr_en || incdec_en;
         n_rem  = m_rem - 1;
         n_done = (n_rem == 0);
      end else begin
         wr_take = wr_en;
         id_take = incdec_en;
`ifdef REG0_HARDWIRED_ZERO_EN
         if (wr_addr == 0) wr_take = 0;
         if (incdec_addr == 0) id_take = 0;
`endif
         if (wr_take && id_take && wr_addr == incdec_addr) begin
            id_take = 0;
            n_drop  = 1;
         end
         if (id_take) begin
            if (!incdec_dir) begin
               if (m_reg[incdec_addr] == 65535) begin nm[incdec_addr] = 0; n_wrap = 1; end
               else nm[incdec_addr] = m_reg[incdec_addr] + 1;
            end else begin
               if (m_reg[incdec_addr] == 0) begin nm[incdec_addr] = 65535; n_wrap = 1; end
               else nm[incdec_addr] = m_reg[incdec_addr] - 1;
            end
         end
         if (wr_take) nm[wr_addr] = wr_data;
         if (clr_req) begin n_rem = 16; n_wrap = 0; end
      end
      @(posedge clk);
      #1;
      m_reg = nm; m_rem = n_rem; m_done = n_done; m_drop = n_drop; m_wrap = n_wrap;
      for (int i = 0; i < 16; i++) chk($sformatf("data%0d", i), 32'(dq[i]), m_reg[i]);
      chk("busy", 32'(busy), 32'(m_rem > 0));
      chk("clr_done", 32'(clr_done), 32'(m_done));
      chk("wr_drop", 32'(wr_drop), 32'(m_drop));
      chk("wrap_flag", 32'(wrap_flag), 32'(m_wrap));
   endtask

   task automatic do_write(input logic [3:0] a, input logic [15:0] d);
      idle_inputs(); wr_en = 1'b1; wr_addr = a; wr_data = d;
      cycle();
      idle_inputs();
   endtask

   task automatic do_incdec(input logic [3:0] a, input logic dir);
      idle_inputs(); incdec_en = 1'b1; incdec_addr = a; incdec_dir = dir;
      cycle();
      idle_inputs();
   endtask

   initial begin
      foreach (m_reg[i]) m_reg[i] = 0;
      m_rem = 0; m_done = 0; m_drop = 0; m_wrap = 0;
      idle_inputs();
      reset = 1'b1;
      cycle(); cycle();
      reset = 1'b0;
      chk("reset_busy", 32'(busy), 32'd0);

      // write visible one edge later
      do_write(4'd3, 16'hA5A5);
      chk("wr3", 32'(dq[3]), 32'h0000A5A5);
      chk("wr3_other", 32'(dq[4]), 32'd0);

      // increment wrap, then decrement wrap
      do_write(4'd7, 16'hFFFF);
      do_incdec(4'd7, 1'b0);
      chk("inc_wrap_data", 32'(dq[7]), 32'd0);
      chk("inc_wrap_flag", 32'(wrap_flag), 32'd1);
      do_incdec(4'd7, 1'b1);
      chk("dec_wrap_data", 32'(dq[7]), 32'h0000FFFF);
      chk("dec_wrap_flag", 32'(wrap_flag), 32'd1);

      // same-address clash, then different addresses
      idle_inputs(); wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h1234;
      incdec_en = 1'b1; incdec_addr = 4'd5;
      cycle();
      chk("clash_data", 32'(dq[5]), 32'h1234);
      chk("clash_drop", 32'(wr_drop), 32'd1);
      idle_inputs(); wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h1234;
      incdec_en = 1'b1; incdec_addr = 4'd6;
      cycle();
      chk("dual_data6", 32'(dq[6]), 32'd1);
      chk("dual_drop", 32'(wr_drop), 32'd0);
      idle_inputs();

`ifdef REG0_HARDWIRED_ZERO_EN
      reset = 1'b1; cycle(); reset = 1'b0;
      do_write(4'd0, 16'hBEEF);
      chk("r0_wr", 32'(dq[0]), 32'd0);
      chk("r0_wr_drop", 32'(wr_drop), 32'd0);
      do_incdec(4'd0, 1'b0);
      chk("r0_inc", 32'(dq[0]), 32'd0);
      chk("r0_inc_drop", 32'(wr_drop), 32'd0);
      chk("r0_wrap", 32'(wrap_flag), 32'd0);
`endif

      // full clear with a write dropped mid-sequence
      for (int i = 0; i < 16; i++) do_write(4'(i), 16'(i + 1));
      idle_inputs(); clr_req = 1'b1;
      cycle();
      idle_inputs();
      for (int k = 1; k <= 16; k++) begin
         if (k == 8) begin wr_en = 1'b1; wr_addr = 4'd15; wr_data = 16'h7777; end
         chk("clr_busy_in", 32'(busy), 32'd1);
         cycle();
         if (k == 8) begin
            chk("clr_wr_drop", 32'(wr_drop), 32'd1);
            chk("clr_wr_ignored", 32'(dq[15]), 32'd16);
            idle_inputs();
         end
      end
      chk("clr_done_pulse", 32'(clr_done), 32'd1);
      chk("clr_busy_fell", 32'(busy), 32'd0);
      cycle();
      chk("clr_done_once", 32'(clr_done), 32'd0);

      // reset aborting a clear
      do_write(4'd9, 16'h5555);
      idle_inputs(); clr_req = 1'b1; cycle(); idle_inputs();
      for (int k = 1; k < 5; k++) cycle();
      reset = 1'b1; cycle(); reset = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_data9", 32'(dq[9]), 32'd0);
      cycle();
      chk("abort_no_done", 32'(clr_done), 32'd0);
      do_write(4'd2, 16'h0BAD);
      chk("abort_wr_ok", 32'(dq[2]), 32'h0BAD);

      // back-to-back clears with clr_req held
      clr_req = 1'b1;
      for (int k = 0; k < 40; k++) cycle();
      idle_inputs();
      for (int k = 0; k < 20; k++) cycle();

      // random traffic
      for (int n = 0; n < 1500; n++) begin
         reset       = ($urandom_range(0, 99) == 0);
         clr_req     = ($urandom_range(0, 39) == 0);
         wr_en       = $urandom_range(0, 1) == 1;
         wr_addr     = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 7))
            0: wr_data = 16'hFFFF;
            1: wr_data = 16'h0000;
            default: wr_data = 16'($urandom);
         endcase
         incdec_en   = $urandom_range(0, 1) == 1;
         incdec_addr = 4'($urandom_range(0, 15));
         incdec_dir  = $urandom_range(0, 1) == 1;
         cycle();
      end
      idle_inputs();
      cycle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/register_bank_16x16.md
Name: register_bank_16x16

Overview:
- Sixteen 16-bit general-purpose registers for the datapath.
- All sixteen register values drive the 16-input, 16-bit read multiplexer directly downstream; that multiplexer selects one register onto the operand bus.
- Provides one write port and one increment/decrement port, e.g. for the program counter or stack pointer.
- A sequenced clear engine zeroes the bank one register per cycle.

Parameters:
- WIDTH, 16, register width in bits; the downstream mux fixes this at 16.
- CLR_START, 0, first register index cleared by the clear sequence; the sequence wraps modulo 16.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  write strobe.
- wr_addr  input  4  write register index.
- wr_data  input  WIDTH  write data.
- incdec_en  input  1  increment/decrement strobe.
- incdec_addr  input  4  target register index.
- incdec_dir  input  1  0 = increment by 1, 1 = decrement by 1.
- clr_req  input  1  start-clear request; level-sampled.
- data0 .. data15  output  WIDTH each  registered contents of registers 0..15.
- busy  output  1  high while the clear sequence runs.
- clr_done  output  1  one-cycle pulse when the clear sequence completes.
- wr_drop  output  1  one-cycle pulse when a write or inc/dec is discarded.
- wrap_flag  output  1  sticky flag; set when inc/dec wraps around.

Behaviour:
- Reset is synchronous, active-high, and takes priority over every other input. While reset is sampled high:
  - all registers are set to 0;
  - busy, clr_done, wr_drop and wrap_flag are set to 0;
  - the FSM goes to IDLE and the clear counter is loaded with CLR_START.
- Reset asserted mid-clear aborts the sequence; no clr_done pulse is produced.
- Outputs data0..data15 are driven straight from the registers. Write latency is 1 cycle: a value written on edge N is visible after edge N. There is no combinational path from write inputs to the data outputs.
- IDLE state:
  - If wr_en is high, reg[wr_addr] <= wr_data.
  - If incdec_en is high, reg[incdec_addr] <= reg[incdec_addr] +/- 1, computed modulo 2^WIDTH.
  - If both are high with the same address, the write wins, the inc/dec is discarded, and wr_drop pulses.
  - If both are high with different addresses, both updates take effect in the same cycle.
  - Wrap-around: 16'hFFFF + 1 gives 16'h0000, and 16'h0000 - 1 gives 16'hFFFF. Either case sets wrap_flag. wrap_flag clears only on reset or at the start of a clear sequence.
  - If clr_req is high, the FSM moves to CLEAR and busy goes to 1 on the next edge. Writes and inc/dec requests in that same cycle are still performed.
- CLEAR state:
  - Each cycle, reg[cnt] <= 0 and cnt <= cnt + 1 (mod 16).
  - The sequence takes exactly 16 cycles. After the 16th register is cleared, the FSM returns to IDLE, busy drops, and clr_done pulses for one cycle on the same edge.
  - Every wr_en or incdec_en seen while busy is discarded, and wr_drop pulses once per cycle containing a discarded request.
  - clr_req is ignored while busy; there is no restart.
  - wrap_flag clears on the edge that enters CLEAR.
- clr_req held high continuously produces back-to-back sequences: 16 cycles busy, 1 cycle IDLE with clr_done high, then busy again.

Optional Feature:
- Macro: REG0_HARDWIRED_ZERO_EN.
- Defined:
  - register 0 is constant 0 and data0 is tied to 0;
  - writes and inc/dec targeting address 0 are silently ignored (no wr_drop pulse, no wrap_flag update);
  - the clear sequence still takes 16 cycles.
- Undefined: register 0 behaves like every other register.

Test Plan:
- Reset, then write 16'hA5A5 to addr 3 -> data3 = 16'hA5A5 one edge later; all other dataN remain 0.
- Write addr 7 = 16'hFFFF, then increment addr 7 -> data7 = 16'h0000 and wrap_flag = 1. Then decrement addr 7 -> data7 = 16'hFFFF and wrap_flag stays 1.
- Same cycle: wr_en addr 5 = 16'h1234 and incdec_en addr 5 -> data5 = 16'h1234 and wr_drop pulses. Repeat with incdec_addr 6 (data6 = 0) -> data6 = 16'h0001 and no wr_drop.
- Fill all registers with nonzero values, pulse clr_req -> busy high for 16 cycles and registers zeroed in order 0..15. A write issued at cycle 8 of the sequence is dropped (wr_drop pulses, target register unchanged), and clr_done pulses as busy falls.
- Start a clear, assert reset at cycle 5 -> all registers 0, busy 0, no clr_done pulse. Afterwards a write is accepted normally.
- With REG0_HARDWIRED_ZERO_EN defined: write addr 0 = 16'hBEEF, then increment addr 0 -> data0 stays 0, no wr_drop pulse, wrap_flag stays 0.
